// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//
// Central pipeline control FSM for a simple in-order core. Decides every cycle
// whether the PC advances, whether a bubble is injected into decode/execute,
// and whether the fetch/decode register is flushed, based on memory stalls,
// control-flow redirects, load-use hazards and a halt instruction in fetch.
//
// Parameters:
//   DRAIN_CYCLES  cycles of bubbles issued after a halt fetch before halted
//                 asserts (legal 1..15)
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   halt_fetch   in   halt instruction present in fetch
//   load_use     in   load-use hazard detected in decode
//   redirect     in   taken branch / jump / jump-register resolved in execute
//   mem_stall    in   instruction/data memory not ready
//   pc_enable    out  PC register update enable (combinational)
//   is_nop       out  inject bubble into decode/execute (combinational)
//   flush_if_id  out  clear fetch/decode pipeline register (combinational)
//   halted       out  processor halted (registered)
//   state        out  current FSM state: RUN=0 STALL_MEM=1 FLUSH=2 DRAIN=3
//                     HALTED=4 (registered, doubles as debug visibility)
//
// Optional build macro PIPELINE_SEQUENCER_PERF_EN adds:
//   stall_cycles out [15:0] cycles with pc_enable=0 outside HALTED, saturating
//   flush_count  out [15:0] cycles with flush_if_id=1, saturating
//
// Handshake note: all inputs are level-sensitive status flags sampled every
// cycle; there is no valid/ready pairing. Priority wherever inputs are sampled
// is mem_stall > redirect > load_use > halt_fetch.
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt_fetch,
  input  logic        load_use,
  input  logic        redirect,
  input  logic        mem_stall,
  output logic        pc_enable,
  output logic        is_nop,
  output logic        flush_if_id,
  output logic        halted,
  output logic [2:0]  state
`ifdef PIPELINE_SEQUENCER_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam logic [2:0] S_RUN       = 3'd0;
  localparam logic [2:0] S_STALL_MEM = 3'd1;
  localparam logic [2:0] S_FLUSH     = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_HALTED    = 3'd4;

  // Counter is loaded with N-1 so that DRAIN lasts exactly N cycles: the
  // transition to HALTED happens on the DRAIN cycle that sees zero.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       halted_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_enable   = 1'b0;
    is_nop      = 1'b0;
    flush_if_id = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          state_d = S_STALL_MEM;
        end else if (redirect) begin
          pc_enable   = 1'b1;
          is_nop      = 1'b1;
          flush_if_id = 1'b1;
          state_d     = S_FLUSH;
        end else if (load_use) begin
          is_nop = 1'b1;
        end else if (halt_fetch) begin
          cnt_d   = DRAIN_LOAD;
          state_d = S_DRAIN;
        end else begin
          pc_enable = 1'b1;
        end
      end

      S_STALL_MEM: begin
        // redirect/load_use are held upstream while stalled, so only
        // mem_stall release matters here.
        if (!mem_stall) state_d = S_RUN;
      end

      S_FLUSH: begin
        is_nop    = 1'b1;
        pc_enable = !mem_stall;
        state_d   = mem_stall ? S_STALL_MEM : S_RUN;
      end

      S_DRAIN: begin
        is_nop = 1'b1;
        if (mem_stall) begin
          // freeze both state and counter
        end else if (redirect) begin
          // Halt was in a branch shadow: abandon the drain.
          pc_enable   = 1'b1;
          flush_if_id = 1'b1;
          cnt_d       = 4'd0;
          state_d     = S_FLUSH;
        end else if (cnt_q == 4'd0) begin
          state_d = S_HALTED;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_HALTED: begin
        is_nop = 1'b1;
      end

      default: begin
        // Unreachable encodings recover to RUN while issuing a bubble.
        is_nop  = 1'b1;
        state_d = S_RUN;
        cnt_d   = 4'd0;
      end
    endcase

    if (reset) begin
      pc_enable   = 1'b0;
      is_nop      = 1'b1;
      flush_if_id = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      cnt_q    <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign state  = state_q;
  assign halted = halted_q;

`ifdef PIPELINE_SEQUENCER_PERF_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (!pc_enable && (state_q != S_HALTED) && (stall_cycles_q != 16'hFFFF))
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (flush_if_id && (flush_count_q != 16'hFFFF))
      flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//
// Self-checking bench for pipeline_sequencer. A behavioural model tracks the
// pipeline mode and the number of bubble cycles still owed before halt; each
// cycle it produces the expected outputs, which go through an expected queue
// and are compared against the DUT. Directed scenarios come first, followed by
// randomized control-flag traffic.
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

  localparam int DC = 4;

  localparam int M_RUN    = 0;
  localparam int M_STALL  = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_DRAIN  = 3;
  localparam int M_HALTED = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       halt_fetch, load_use, redirect, mem_stall;
  logic       pc_enable, is_nop, flush_if_id, halted;
  logic [2:0] state;
`ifdef PIPELINE_SEQUENCER_PERF_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  pipeline_sequencer #(.DRAIN_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .halt_fetch  (halt_fetch),
    .load_use    (load_use),
    .redirect    (redirect),
    .mem_stall   (mem_stall),
    .pc_enable   (pc_enable),
    .is_nop      (is_nop),
    .flush_if_id (flush_if_id),
    .halted      (halted),
    .state       (state)
`ifdef PIPELINE_SEQUENCER_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  // {state[2:0], halted, flush_if_id, is_nop, pc_enable}
  logic [6:0] exp_q[$];

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode      = M_RUN;
  int drain_left  = 0;   // bubble cycles still owed before halt
  int m_stall     = 0;
  int m_flush     = 0;

  task automatic step(input logic rst, input logic hf, input logic lu,
                      input logic rd, input logic ms);
    logic e_pc, e_nop, e_fl;
    int   nxt, nleft;
    logic [6:0] e;
    @(negedge clk);
    reset = rst; halt_fetch = hf; load_use = lu; redirect = rd; mem_stall = ms;
    #1;
    nxt = m_mode; nleft = drain_left;
    e_pc = 1'b0; e_nop = 1'b0; e_fl = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (ms) nxt = M_STALL;
        else if (rd) begin e_pc = 1; e_nop = 1; e_fl = 1; nxt = M_FLUSH; end
        else if (lu) e_nop = 1;
        else if (hf) begin nxt = M_DRAIN; nleft = DC; end
        else e_pc = 1;
      end
      M_STALL: if (!ms) nxt = M_RUN;
      M_FLUSH: begin
        e_nop = 1; e_pc = !ms;
        nxt = ms ? M_STALL : M_RUN;
      end
      M_DRAIN: begin
        e_nop = 1;
        if (ms) ;
        else if (rd) begin e_pc = 1; e_fl = 1; nxt = M_FLUSH; end
        else begin
          nleft = nleft - 1;
          if (nleft == 0) nxt = M_HALTED;
        end
      end
      default: e_nop = 1;   // halted
    endcase
    if (rst) begin e_pc = 0; e_nop = 1; e_fl = 0; end

    e = {3'(m_mode), (m_mode == M_HALTED), e_fl, e_nop, e_pc};
    exp_q.push_back(e);
    e = exp_q.pop_front();
    check_val("pc_enable",   {15'd0, pc_enable},   {15'd0, e[0]});
    check_val("is_nop",      {15'd0, is_nop},      {15'd0, e[1]});
    check_val("flush_if_id", {15'd0, flush_if_id}, {15'd0, e[2]});
    check_val("halted",      {15'd0, halted},      {15'd0, e[3]});
    check_val("state",       {13'd0, state},       {13'd0, e[6:4]});
`ifdef PIPELINE_SEQUENCER_PERF_EN
    check_val("stall_cycles", stall_cycles, 16'(m_stall));
    check_val("flush_count",  flush_count,  16'(m_flush));
`endif

    if (rst) begin
      m_mode = M_RUN; drain_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc && m_mode != M_HALTED && m_stall < 65535) m_stall++;
      if (e_fl && m_flush < 65535) m_flush++;
      m_mode = nxt; drain_left = nleft;
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; halt_fetch = 0; load_use = 0; redirect = 0; mem_stall = 0;
    repeat (2) @(posedge clk);

    // reset asserted with known state, then idle running
    step(1, 0, 0, 0, 0);
    idle(3);
    // memory stall for three cycles
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    idle(2);
    // redirect and load-use together: redirect wins
    step(0, 0, 1, 1, 0);
    idle(2);
    // load-use alone, then halt and full drain
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(DC + 3);
    // reset out of HALTED
    step(1, 0, 0, 0, 0);
    idle(1);
    // halt aborted by redirect in second drain cycle
    step(0, 1, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0);
    idle(DC + 3);
    // drain held by mem_stall, then completes
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    idle(DC + 2);
    // reset mid-drain
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0);
    idle(2);
    // flush followed by mem_stall, and the perf scenario
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, h, l, b, s;
      r = ($urandom_range(0, 149) == 0) ||
          (m_mode == M_HALTED && $urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 11) == 0);
      l = ($urandom_range(0, 5) == 0);
      b = ($urandom_range(0, 7) == 0);
      s = ($urandom_range(0, 6) == 0);
      step(r, h, l, b, s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
